// File: rtl/raster_focal_mean_stream_pkg.sv
// Shared constants and helpers for the raster 2x2 focal-mean stream block.
package rfm_pkg;

  typedef enum logic {
    MODE_TRUNC = 1'b0,
    MODE_ROUND = 1'b1
  } mode_e;

  // Counter width for a raster dimension; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/raster_focal_mean_stream_if.sv
// Pixel-in / mean-out stream handshake bundle for raster_focal_mean_stream.
interface raster_focal_mean_stream_if #(
  parameter int unsigned PIX_W = 4
);

  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_last;

  modport master (
    output mode, in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  mode, in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/raster_focal_mean_stream_line_buffer.sv
// One-row pixel delay line; the tap is the pixel accepted IMG_W transfers ago.
module rfm_line_buffer #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned IMG_W = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] tap
);

  logic [IMG_W*PIX_W-1:0] sr_q;
  logic [IMG_W*PIX_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = {sr_q[(IMG_W-1)*PIX_W-1:0], din};
    end
  end

  // Contents deliberately not reset: row 0 never emits, so stale data is harmless.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign tap = sr_q[IMG_W*PIX_W-1 -: PIX_W];

endmodule

// File: rtl/raster_focal_mean_stream.sv
// Streaming 2x2 focal mean over a raster frame, truncating or round-half-up.
module raster_focal_mean_stream
  import rfm_pkg::*;
#(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input logic                        clk,
  input logic                        rst,
  raster_focal_mean_stream_if.slave  bus
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] prev_q, prev_d;
  logic [PIX_W-1:0] diag_q, diag_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             in_ready;
  logic             in_xfer;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             emit;
  logic             is_last;
  logic [PIX_W-1:0] tap;
  logic [PIX_W+1:0] sum;
  logic [PIX_W+2:0] sum_rnd;
  logic [PIX_W:0]   rnd;
  logic [PIX_W-1:0] mean_trunc;
  logic [PIX_W-1:0] mean_round;
  logic [PIX_W-1:0] mean;
  mode_e            mode_sel;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_ready;

  rfm_line_buffer #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk (clk),
    .en  (in_xfer),
    .din (bus.in_data),
    .tap (tap)
  );

  // in_sof forces the current pixel to (0,0) whatever the counters hold.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    emit    = (cur_col != '0) && (cur_row != '0);
    is_last = (cur_col == COL_MAX) && (cur_row == ROW_MAX);
  end

  // Window: diag = P(r-1,c-1), tap = P(r-1,c), prev = P(r,c-1), in_data = P(r,c).
  always_comb begin
    mode_sel   = mode_e'(bus.mode);
    sum        = {2'b00, diag_q} + {2'b00, tap} + {2'b00, prev_q} + {2'b00, bus.in_data};
    sum_rnd    = {1'b0, sum} + (PIX_W+3)'(2);
    rnd        = (PIX_W+1)'(sum_rnd >> 2);
    mean_trunc = sum[PIX_W+1:2];
    mean_round = rnd[PIX_W] ? '1 : rnd[PIX_W-1:0];
    mean       = (mode_sel == MODE_ROUND) ? mean_round : mean_trunc;
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    prev_d = prev_q;
    diag_d = diag_q;
    if (in_xfer) begin
      prev_d = bus.in_data;
      diag_d = tap;
      if (cur_col == COL_MAX) begin
        col_d = '0;
        row_d = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // A qualifying transfer reloads the register even while the old value drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (in_xfer && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = mean;
      out_last_d  = is_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      prev_q      <= '0;
      diag_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      diag_q      <= diag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/raster_focal_mean_stream.md
RASTER_FOCAL_MEAN_STREAM -- requirements
Module: raster_focal_mean_stream

Interface
REQ-001 Parameter PIX_W, default 4, pixel width in bits (legal range 2..16).
REQ-002 Parameter IMG_W, default 8, raster columns per row (legal range 2..256).
REQ-003 Parameter IMG_H, default 8, raster rows per frame (legal range 2..256).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port mode  input  1  0 = truncating mean, 1 = round-half-up mean; sampled on each input transfer.
REQ-007 Port in_valid  input  1  input pixel valid.
REQ-008 Port in_ready  output  1  block can accept an input pixel.
REQ-009 Port in_sof  input  1  pixel is raster position (row 0, col 0); qualified by transfer.
REQ-010 Port in_data  input  PIX_W  input pixel value, row-major order.
REQ-011 Port out_valid  output  1  output mean valid.
REQ-012 Port out_ready  input  1  downstream accepts output.
REQ-013 Port out_data  output  PIX_W  2x2 focal mean.
REQ-014 Port out_last  output  1  marks the final output of a frame.

Function
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready (single output register, no combinational in_valid->in_ready path).
REQ-017 Column counter col counts 0..IMG_W-1 on each input transfer; at IMG_W-1 it wraps to 0 and row increments.
REQ-018 Row counter row counts 0..IMG_H-1; after (IMG_H-1, IMG_W-1) both counters wrap to 0.
REQ-019 A transfer with in_sof=1 is taken as (0,0) regardless of counter state; counters resume at (0,1).
REQ-020 A line buffer holds the most recent IMG_W accepted pixels; its tap gives pixel (row-1, col) for the current pixel.
REQ-021 Window for transfer at (r,c) with r>=1, c>=1: P(r-1,c-1), P(r-1,c), P(r,c-1), P(r,c).
REQ-022 Sum width is PIX_W+2 bits with no overflow; mode 0 gives out = sum>>2; mode 1 gives out = (sum+2)>>2.
REQ-023 Mode 1 saturates: if (sum+2)>>2 exceeds 2^PIX_W-1, out_data = 2^PIX_W-1.
REQ-024 A transfer with r>=1 and c>=1 loads out_data and sets out_valid on the next edge; latency is 1 cycle.
REQ-025 Transfers with r=0 or c=0 produce no output; they update only the line buffer and the previous-pixel register.
REQ-026 Each frame yields exactly (IMG_H-1)*(IMG_W-1) outputs; out_last=1 only on the output from input (IMG_H-1, IMG_W-1).
REQ-027 When out_valid=1 and out_ready=0, out_data, out_last and out_valid stay stable, and no input is accepted.
REQ-028 When an output transfer and a new qualifying input transfer happen in the same cycle, the register reloads; no bubble is inserted.
REQ-029 Line buffer content from the previous frame after in_sof is don't-care; row 0 never emits output, so stale data never reaches out_data.

Reset
REQ-030 When rst=1 at a clock edge: out_valid=0, out_data=0, out_last=0, row=0, col=0, and the previous-pixel register is 0.
REQ-031 Line buffer contents are not reset.
REQ-032 in_ready=1 in the cycle after reset.
REQ-033 Reset asserted mid-frame abandons the frame; the next accepted pixel is treated as (0,0).

Structure
REQ-034 Package rfm_pkg holds the MODE_TRUNC=0 and MODE_ROUND=1 constants and a function giving the counter width as clog2 of a dimension.
REQ-035 Sub-module rfm_line_buffer is a PIX_W x IMG_W shift register with enable, advanced only on an input transfer.
REQ-036 The sum, rounding and saturation logic is combinational, placed between the window registers and the output register.

Verification
REQ-037 Defaults, mode 0, out_ready=1, frame of pixels = (r+c) mod 16 -> 49 outputs; (1,1) gives 1, (7,7) gives 13 with out_last=1.
REQ-038 Mode 1, all pixels 15 -> every out_data=15 (saturation path); mode 1 window {1,1,1,2} -> sum 5 -> out 1; window {1,1,2,2} -> out 2; mode 0 same -> 1.
REQ-039 Backpressure: out_ready=0 for 5 cycles after the first output -> in_ready=0, out_data held, no pixel lost; the output stream matches the golden model.
REQ-040 Random in_valid and out_ready (50%), 3 frames -> 147 outputs, all matching the scoreboard, with exactly 3 out_last pulses.
REQ-041 in_sof asserted at mid-row of frame 1 (r=3, c=4) -> counters resync; the next 49 outputs match a fresh frame.
REQ-042 rst pulsed mid-frame -> out_valid=0 on the next edge; the following frame produces 49 correct outputs.
